// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding and default sizes for the matmul tile scheduler
package matmul_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, RELEASE, ADVANCE, DONE} state_t;
  localparam int AWIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;
endpackage

// File: rtl/matmul_tile_scheduler_tile_addr_gen.sv
// tile_addr_gen: k-n-m tile index counters with incremental BRAM A/B/C address registers
module tile_addr_gen import matmul_pkg::*; #(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [CNT_WIDTH-1:0] cnt_m,
  input  logic [CNT_WIDTH-1:0] cnt_n,
  input  logic [CNT_WIDTH-1:0] cnt_k,
  input  logic [AWIDTH-1:0]    base_a,
  input  logic [AWIDTH-1:0]    base_b,
  input  logic [AWIDTH-1:0]    base_c,
  input  logic [AWIDTH-1:0]    stride_a,
  input  logic [AWIDTH-1:0]    stride_b,
  input  logic [AWIDTH-1:0]    stride_c,
  output logic [CNT_WIDTH-1:0] tile_m,
  output logic [CNT_WIDTH-1:0] tile_n,
  output logic [CNT_WIDTH-1:0] tile_k,
  output logic [AWIDTH-1:0]    addr_a,
  output logic [AWIDTH-1:0]    addr_b,
  output logic [AWIDTH-1:0]    addr_c,
  output logic                 last
);
  logic [AWIDTH-1:0] row_a, col_b, nsb, nsb_calc;
  logic k_wrap, n_wrap;
  assign k_wrap = tile_k == cnt_k - 1'b1;
  assign n_wrap = tile_n == cnt_n - 1'b1;
  assign last = k_wrap && n_wrap && tile_m == cnt_m - 1'b1;
  // B steps by N*stride_b per k; formed once per job by shift-and-add
  always_comb begin
    nsb_calc = '0;
    for (int i = 0; i < CNT_WIDTH; i++) nsb_calc = cnt_n[i] ? nsb_calc + (stride_b << i) : nsb_calc;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tile_m <= '0;
      tile_n <= '0;
      tile_k <= '0;
      addr_a <= '0;
      addr_b <= '0;
      addr_c <= '0;
      row_a  <= '0;
      col_b  <= '0;
      nsb    <= '0;
    end else if (load) begin
      tile_m <= '0;
      tile_n <= '0;
      tile_k <= '0;
      addr_a <= base_a;
      row_a  <= base_a;
      addr_b <= base_b;
      col_b  <= base_b;
      nsb    <= nsb_calc;
      addr_c <= base_c;
    end else if (step) begin
      if (!k_wrap) begin
        tile_k <= tile_k + 1'b1;
        addr_a <= addr_a + stride_a;
        addr_b <= addr_b + nsb;
      end else begin
        tile_k <= '0;
        addr_c <= addr_c + stride_c;
        if (!n_wrap) begin
          tile_n <= tile_n + 1'b1;
          addr_a <= row_a;
          addr_b <= col_b + stride_b;
          col_b  <= col_b + stride_b;
        end else begin
          tile_n <= '0;
          tile_m <= tile_m + 1'b1;
          addr_a <= addr_a + stride_a;
          row_a  <= addr_a + stride_a;
          addr_b <= base_b;
          col_b  <= base_b;
        end
      end
    end
  end
endmodule

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler: walks an MxNxK tile grid driving the 8x8 engine; MATMUL_SCHED_TIMEOUT_EN adds a WAIT/RELEASE watchdog and error
module matmul_tile_scheduler import matmul_pkg::*; #(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
`ifdef MATMUL_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear_done,
  input  logic [CNT_WIDTH-1:0] num_m_tiles,
  input  logic [CNT_WIDTH-1:0] num_n_tiles,
  input  logic [CNT_WIDTH-1:0] num_k_tiles,
  input  logic [AWIDTH-1:0]    base_a,
  input  logic [AWIDTH-1:0]    base_b,
  input  logic [AWIDTH-1:0]    base_c,
  input  logic [AWIDTH-1:0]    tile_stride_a,
  input  logic [AWIDTH-1:0]    tile_stride_b,
  input  logic [AWIDTH-1:0]    tile_stride_c,
  input  logic                 mm_done,
  output logic                 mm_start,
  output logic [AWIDTH-1:0]    mm_addr_a,
  output logic [AWIDTH-1:0]    mm_addr_b,
  output logic [AWIDTH-1:0]    mm_addr_c,
  output logic                 mm_accumulate,
  output logic [CNT_WIDTH-1:0] tile_m,
  output logic [CNT_WIDTH-1:0] tile_n,
  output logic [CNT_WIDTH-1:0] tile_k,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          runs_done
`ifdef MATMUL_SCHED_TIMEOUT_EN
  , output logic               error
`endif
);
  state_t state, next;
  logic [CNT_WIDTH-1:0] cfg_m, cfg_n, cfg_k;
  logic [AWIDTH-1:0] cfg_ba, cfg_bb, cfg_bc, cfg_sa, cfg_sb, cfg_sc;
  logic last, timeout, accept;
  assign accept = state == IDLE && start;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  assign mm_accumulate = tile_k != '0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
  logic [15:0] wd;
  assign timeout = (state == WAIT || state == RELEASE) && wd == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd    <= '0;
      error <= 1'b0;
    end else begin
      wd    <= (next != state || !(state == WAIT || state == RELEASE)) ? '0 : wd + 1'b1;
      error <= (state == DONE && clear_done) ? 1'b0 : timeout ? 1'b1 : error;
    end
  end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = !start ? IDLE : (num_m_tiles == '0 || num_n_tiles == '0 || num_k_tiles == '0) ? DONE : SETUP;
      SETUP:   next = ISSUE;
      ISSUE:   next = WAIT;
      WAIT:    next = mm_done ? RELEASE : timeout ? DONE : WAIT;
      RELEASE: next = !mm_done ? ADVANCE : timeout ? DONE : RELEASE;
      ADVANCE: next = last ? DONE : ISSUE;
      DONE:    next = clear_done ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mm_start  <= 1'b0;
      runs_done <= '0;
    end else begin
      state     <= next;
      mm_start  <= next == WAIT;
      runs_done <= accept ? '0 : (state == WAIT && mm_done) ? runs_done + 1'b1 : runs_done;
    end
  end
  // job configuration is captured once so host writes mid-job are harmless
  always_ff @(posedge clk) begin
    if (accept) begin
      cfg_m  <= num_m_tiles;
      cfg_n  <= num_n_tiles;
      cfg_k  <= num_k_tiles;
      cfg_ba <= base_a;
      cfg_bb <= base_b;
      cfg_bc <= base_c;
      cfg_sa <= tile_stride_a;
      cfg_sb <= tile_stride_b;
      cfg_sc <= tile_stride_c;
    end
  end
  tile_addr_gen #(.AWIDTH(AWIDTH), .CNT_WIDTH(CNT_WIDTH)) u_gen (
    .clk(clk), .reset(reset), .load(state == SETUP), .step(state == ADVANCE && !last),
    .cnt_m(cfg_m), .cnt_n(cfg_n), .cnt_k(cfg_k),
    .base_a(cfg_ba), .base_b(cfg_bb), .base_c(cfg_bc),
    .stride_a(cfg_sa), .stride_b(cfg_sb), .stride_c(cfg_sc),
    .tile_m(tile_m), .tile_n(tile_n), .tile_k(tile_k),
    .addr_a(mm_addr_a), .addr_b(mm_addr_b), .addr_c(mm_addr_c), .last(last)
  );
endmodule
